// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: realigns 32-bit fetch words into whole RVC/32-bit instructions
// and presents them to decode through a small FIFO with valid/ready.
// Optional same-cycle bypass when the FIFO is empty: define FETCH_ENTRY_QUEUE_BYPASS_EN.
module fetch_entry_queue #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic [VLEN-1:0] fetch_addr_i,
    input  logic            fetch_ex_i,
    output logic            fetch_entry_valid_o,
    input  logic            fetch_entry_ready_i,
    output logic [31:0]     fetch_entry_instr_o,
    output logic [VLEN-1:0] fetch_entry_addr_o,
    output logic            fetch_entry_ex_o,
    output logic            fetch_entry_is_compressed_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            ex;
    } entry_t;

    // Realigner state
    logic            unaligned_q, unaligned_d;
    logic            hw_q, hw_d;
    logic [15:0]     held_q, held_d;
    logic [VLEN-1:0] uaddr_q, uaddr_d;

    // FIFO state
    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;

    logic            full, empty, step, hw_eff;
    logic            push_req, consume, wr_en, pop, bypass, out_valid;
    logic [VLEN-1:0] upper_addr;
    entry_t          push_entry, head;
    logic            unused_addr0;

    // Bit 0 of the address is always zero for halfword-aligned fetch
    assign unused_addr0 = fetch_addr_i[0];

    assign full       = (count_q == CntW'(DEPTH));
    assign empty      = (count_q == '0);
    assign step       = fetch_valid_i && !full && !flush_i;
    assign hw_eff     = hw_q | fetch_addr_i[1];
    assign upper_addr = {fetch_addr_i[VLEN-1:2], 2'b10};

    // Realigner: pick this word's contribution and the next realign state
    always_comb begin
        push_req    = 1'b0;
        consume     = 1'b0;
        push_entry  = '0;
        unaligned_d = unaligned_q;
        hw_d        = hw_q;
        held_d      = held_q;
        uaddr_d     = uaddr_q;
        if (step) begin
            if (fetch_ex_i) begin
                // Faulting word is reported at the PC of the instruction it would complete
                push_req         = 1'b1;
                consume          = 1'b1;
                push_entry.instr = fetch_data_i;
                push_entry.addr  = unaligned_q ? uaddr_q : fetch_addr_i;
                push_entry.ex    = 1'b1;
                unaligned_d      = 1'b0;
                hw_d             = 1'b0;
            end else if (unaligned_q) begin
                // Low half of this word completes the straddling instruction
                push_req         = 1'b1;
                push_entry.instr = {fetch_data_i[15:0], held_q};
                push_entry.addr  = uaddr_q;
                unaligned_d      = 1'b0;
                hw_d             = 1'b1;
            end else if (!hw_eff) begin
                push_req        = 1'b1;
                push_entry.addr = fetch_addr_i;
                if (fetch_data_i[1:0] != 2'b11) begin
                    push_entry.instr = {16'b0, fetch_data_i[15:0]};
                    hw_d             = 1'b1;
                end else begin
                    push_entry.instr = fetch_data_i;
                    consume          = 1'b1;
                    hw_d             = 1'b0;
                end
            end else if (fetch_data_i[17:16] != 2'b11) begin
                push_req         = 1'b1;
                consume          = 1'b1;
                push_entry.instr = {16'b0, fetch_data_i[31:16]};
                push_entry.addr  = upper_addr;
                hw_d             = 1'b0;
            end else begin
                // Upper half starts a 32-bit instruction: hold it for the next word
                consume     = 1'b1;
                held_d      = fetch_data_i[31:16];
                uaddr_d     = upper_addr;
                unaligned_d = 1'b1;
                hw_d        = 1'b0;
            end
        end
        if (flush_i) begin
            unaligned_d = 1'b0;
            hw_d        = 1'b0;
        end
    end

`ifdef FETCH_ENTRY_QUEUE_BYPASS_EN
    // push_req already excludes flush, so a flush also kills the bypass
    assign bypass = empty && push_req;
`else
    assign bypass = 1'b0;
`endif

    assign head      = bypass ? push_entry : mem_q[rptr_q];
    assign out_valid = !empty || bypass;
    assign pop       = !empty && fetch_entry_ready_i && !flush_i;
    assign wr_en     = push_req && !(bypass && fetch_entry_ready_i);

    assign fetch_ready_o               = consume;
    assign fetch_entry_valid_o         = out_valid;
    assign fetch_entry_instr_o         = out_valid ? head.instr : 32'b0;
    assign fetch_entry_addr_o          = out_valid ? head.addr : '0;
    assign fetch_entry_ex_o            = out_valid && head.ex;
    assign fetch_entry_is_compressed_o = out_valid && (head.instr[1:0] != 2'b11);

    // Realigner registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unaligned_q <= 1'b0;
            hw_q        <= 1'b0;
            held_q      <= '0;
            uaddr_q     <= '0;
        end else begin
            unaligned_q <= unaligned_d;
            hw_q        <= hw_d;
            held_q      <= held_d;
            uaddr_q     <= uaddr_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; outputs are gated by valid so no reset is needed here
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Bench for fetch_entry_queue: directed scenarios plus randomized traffic, every cycle
// checked against a queue-based model of the realign rules.
module tb_fetch_entry_queue;

    localparam int unsigned VLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OW    = VLEN + 36;

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            ex;
        logic            comp;
    } rec_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            fetch_valid_i = 1'b0;
    logic            fetch_ready_o;
    logic [31:0]     fetch_data_i = '0;
    logic [VLEN-1:0] fetch_addr_i = '0;
    logic            fetch_ex_i = 1'b0;
    logic            fetch_entry_valid_o;
    logic            fetch_entry_ready_i = 1'b0;
    logic [31:0]     fetch_entry_instr_o;
    logic [VLEN-1:0] fetch_entry_addr_o;
    logic            fetch_entry_ex_o;
    logic            fetch_entry_is_compressed_o;

    int total = 0;
    int bad   = 0;

    // Model state: queued entries plus pending-half bookkeeping
    rec_t            mq[$];
    logic            m_unal = 1'b0;
    logic            m_hw = 1'b0;
    logic [15:0]     m_held = '0;
    logic [VLEN-1:0] m_uaddr = '0;

    // Entries decode actually accepted, for the directed constant checks
    rec_t got[$];

    fetch_entry_queue #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i                       (clk_i),
        .rst_ni                      (rst_ni),
        .flush_i                     (flush_i),
        .fetch_valid_i               (fetch_valid_i),
        .fetch_ready_o               (fetch_ready_o),
        .fetch_data_i                (fetch_data_i),
        .fetch_addr_i                (fetch_addr_i),
        .fetch_ex_i                  (fetch_ex_i),
        .fetch_entry_valid_o         (fetch_entry_valid_o),
        .fetch_entry_ready_i         (fetch_entry_ready_i),
        .fetch_entry_instr_o         (fetch_entry_instr_o),
        .fetch_entry_addr_o          (fetch_entry_addr_o),
        .fetch_entry_ex_o            (fetch_entry_ex_o),
        .fetch_entry_is_compressed_o (fetch_entry_is_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1);
    end

    function automatic rec_t mk(input logic [31:0] instr, input logic [VLEN-1:0] addr,
                                input logic ex);
        rec_t r;
        r.instr = instr;
        r.addr  = addr;
        r.ex    = ex;
        r.comp  = (instr[1:0] != 2'b11);
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_unal  = 1'b0;
        m_hw    = 1'b0;
        m_held  = '0;
        m_uaddr = '0;
    endfunction

    // One cycle: drive inputs, compare all outputs to the model, advance model, next negedge
    task automatic tick(input logic fv, input logic [31:0] w, input logic [VLEN-1:0] a,
                        input logic ex, input logic rdy, input logic fl, output logic cons_o);
        logic [OW-1:0]   o, e;
        rec_t            pe, hd;
        logic            stp, hwe, do_push, cons, v, byp;
        logic [VLEN-1:0] ha;
        fetch_valid_i       = fv;
        fetch_data_i        = w;
        fetch_addr_i        = a;
        fetch_ex_i          = ex;
        fetch_entry_ready_i = rdy;
        flush_i             = fl;
        #1;
        o = {fetch_entry_valid_o, fetch_entry_instr_o, fetch_entry_addr_o, fetch_entry_ex_o,
             fetch_entry_is_compressed_o, fetch_ready_o};
        stp     = fv && (mq.size() < DEPTH) && !fl;
        hwe     = m_hw || a[1];
        ha      = {a[VLEN-1:2], 2'b10};
        do_push = 1'b0;
        cons    = 1'b0;
        pe      = '0;
        if (ex) begin
            pe = mk(w, m_unal ? m_uaddr : a, 1'b1);
            do_push = 1'b1;
            cons = 1'b1;
        end else if (m_unal) begin
            pe = mk({w[15:0], m_held}, m_uaddr, 1'b0);
            do_push = 1'b1;
        end else if (!hwe) begin
            do_push = 1'b1;
            if (w[1:0] != 2'b11) begin
                pe = mk({16'h0, w[15:0]}, a, 1'b0);
            end else begin
                pe = mk(w, a, 1'b0);
                cons = 1'b1;
            end
        end else begin
            cons = 1'b1;
            if (w[17:16] != 2'b11) begin
                pe = mk({16'h0, w[31:16]}, ha, 1'b0);
                do_push = 1'b1;
            end
        end
        v  = (mq.size() != 0);
        hd = v ? mq[0] : '0;
        byp = 1'b0;
`ifdef FETCH_ENTRY_QUEUE_BYPASS_EN
        if (!v && stp && do_push) begin
            v   = 1'b1;
            hd  = pe;
            byp = 1'b1;
        end
`endif
        e = {v, hd.instr, hd.addr, hd.ex, v && hd.comp, stp && cons};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL model_cycle t=%0t got=%h want=%h", $time, o, e);
        end
        if (fetch_entry_valid_o && rdy && !fl) begin
            got.push_back('{fetch_entry_instr_o, fetch_entry_addr_o, fetch_entry_ex_o,
                            fetch_entry_is_compressed_o});
        end
        if (fl) begin
            model_reset();
        end else begin
            if (mq.size() != 0 && rdy) begin
                void'(mq.pop_front());
            end
            if (stp && do_push && !(byp && rdy)) begin
                mq.push_back(pe);
            end
            if (stp) begin
                if (ex) begin
                    m_unal = 1'b0;
                    m_hw   = 1'b0;
                end else if (m_unal) begin
                    m_unal = 1'b0;
                    m_hw   = 1'b1;
                end else if (!hwe) begin
                    m_hw = (w[1:0] != 2'b11);
                end else begin
                    m_hw = 1'b0;
                    if (w[17:16] == 2'b11) begin
                        m_held  = w[31:16];
                        m_uaddr = ha;
                        m_unal  = 1'b1;
                    end
                end
            end
        end
        cons_o = stp && cons;
        @(negedge clk_i);
    endtask

    // Present one word until consumed (bounded)
    task automatic feed(input logic [31:0] w, input logic [VLEN-1:0] a, input logic ex,
                        input logic rdy);
        logic c;
        int   n;
        c = 1'b0;
        n = 0;
        while (!c && n < 12) begin
            tick(1'b1, w, a, ex, rdy, 1'b0, c);
            n++;
        end
        total++;
        if (!c) begin
            bad++;
            $display("FAIL feed_timeout w=%h got=not_consumed want=consumed", w);
        end
    endtask

    task automatic drain(input int n);
        logic c;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0, c);
        end
    endtask

    task automatic test_reset();
        logic c;
        @(negedge clk_i);
        #2;
        total++;
        if ({fetch_ready_o, fetch_entry_valid_o, fetch_entry_instr_o, fetch_entry_addr_o,
             fetch_entry_ex_o, fetch_entry_is_compressed_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%h/%h want=all_zero", fetch_ready_o,
                     fetch_entry_valid_o, fetch_entry_instr_o, fetch_entry_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic test_rvc_pair();
        logic r1, r2;
        got.delete();
        tick(1'b1, 32'h4501_4081, 64'h1000, 1'b0, 1'b1, 1'b0, r1);
        tick(1'b1, 32'h4501_4081, 64'h1000, 1'b0, 1'b1, 1'b0, r2);
        drain(4);
        total++;
        if (r1 !== 1'b0 || r2 !== 1'b1) begin
            bad++;
            $display("FAIL rvc_ready_seq got=%b%b want=01", r1, r2);
        end
        total++;
        if (got.size() != 2 || got[0] !== mk(32'h4081, 64'h1000, 1'b0) ||
            got[1] !== mk(32'h4501, 64'h1002, 1'b0)) begin
            bad++;
            $display("FAIL rvc_entries got_n=%0d want_n=2 (0x4081@0x1000, 0x4501@0x1002)",
                     got.size());
        end
    endtask

    task automatic test_straddle();
        got.delete();
        feed(32'h0013_4081, 64'h2000, 1'b0, 1'b1);
        feed(32'h4501_0593, 64'h2004, 1'b0, 1'b1);
        drain(4);
        total++;
        if (got.size() != 3 || got[0] !== mk(32'h4081, 64'h2000, 1'b0) ||
            got[1] !== mk(32'h0593_0013, 64'h2002, 1'b0) ||
            got[2] !== mk(32'h4501, 64'h2006, 1'b0)) begin
            bad++;
            $display("FAIL straddle_entries got_n=%0d want_n=3 (0x05930013@0x2002 c=0)",
                     got.size());
        end
    endtask

    task automatic test_hw_jump();
        logic c;
        got.delete();
        tick(1'b1, 32'h8082_1234, 64'h3002, 1'b0, 1'b1, 1'b0, c);
        drain(3);
        total++;
        if (c !== 1'b1) begin
            bad++;
            $display("FAIL hw_jump_consume got=%b want=1", c);
        end
        total++;
        if (got.size() != 1 || got[0] !== mk(32'h8082, 64'h3002, 1'b0)) begin
            bad++;
            $display("FAIL hw_jump_entry got_n=%0d want_n=1 (0x8082@0x3002)", got.size());
        end
    endtask

    task automatic test_ex_unaligned();
        got.delete();
        feed(32'h0013_1234, 64'h4FFE, 1'b0, 1'b1);
        feed(32'hDEAD_BEEF, 64'h5000, 1'b1, 1'b1);
        feed(32'h4501_4081, 64'h5004, 1'b0, 1'b1);
        drain(4);
        total++;
        if (got.size() != 3 || got[0] !== mk(32'hDEAD_BEEF, 64'h4FFE, 1'b1) ||
            got[1] !== mk(32'h4081, 64'h5004, 1'b0) ||
            got[2] !== mk(32'h4501, 64'h5006, 1'b0)) begin
            bad++;
            $display("FAIL ex_unaligned got_n=%0d want_n=3 (ex@0x4FFE then 0x4081@0x5004)",
                     got.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [10];
        logic        c;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            words[i] = 32'h0000_0033 | (32'(i) << 8);
        end
        for (int i = 0; i < 4; i++) begin
            feed(words[i], 64'h6000 + 64'(4 * i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, words[4], 64'h6010, 1'b0, 1'b0, 1'b0, c);
            total++;
            if (c !== 1'b0) begin
                bad++;
                $display("FAIL full_stall got=%b want=0", c);
            end
        end
        for (int i = 4; i < 10; i++) begin
            feed(words[i], 64'h6000 + 64'(4 * i), 1'b0, 1'b1);
        end
        drain(8);
        total++;
        if (got.size() != 10) begin
            bad++;
            $display("FAIL drain_count got=%0d want=10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            total++;
            if (got[i] !== mk(words[i], 64'h6000 + 64'(4 * i), 1'b0)) begin
                bad++;
                $display("FAIL drain_order idx=%0d got=%h want=%h", i, got[i].instr, words[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic c;
        feed(32'h4501_4081, 64'h7000, 1'b0, 1'b0);
        feed(32'h0013_4081, 64'h7004, 1'b0, 1'b0);
        tick(1'b1, 32'h4501_0593, 64'h8000, 1'b0, 1'b1, 1'b1, c);
        total++;
        if (c !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready got=%b want=0", c);
        end
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        #1;
        total++;
        if (fetch_entry_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_valid got=%b want=0", fetch_entry_valid_o);
        end
        got.delete();
        feed(32'h4501_0593, 64'h8000, 1'b0, 1'b1);
        drain(3);
        total++;
        if (got.size() != 1 || got[0] !== mk(32'h4501_0593, 64'h8000, 1'b0)) begin
            bad++;
            $display("FAIL flush_fresh got_n=%0d want_n=1 (0x45010593@0x8000)", got.size());
        end
    endtask

    task automatic test_async_reset();
        logic c;
        feed(32'h4501_4081, 64'h9000, 1'b0, 1'b0);
        fetch_valid_i = 1'b0;
        #7;
        rst_ni = 1'b0;
        #1;
        total++;
        if (fetch_entry_valid_o !== 1'b0 || fetch_entry_instr_o !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got=%b/%h want=0/00000000", fetch_entry_valid_o,
                     fetch_entry_instr_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0, c);
        // A fresh word after reset must start clean (no leftover half)
        got.delete();
        feed(32'h4501_4081, 64'hA000, 1'b0, 1'b1);
        drain(3);
        total++;
        if (got.size() != 2 || got[0] !== mk(32'h4081, 64'hA000, 1'b0)) begin
            bad++;
            $display("FAIL post_reset got_n=%0d want_n=2", got.size());
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            h[1:0] = 2'b11;
        end else if (h[1:0] == 2'b11) begin
            h[0] = 1'b0;
        end
        return h;
    endfunction

    task automatic test_random();
        logic [31:0]     cw;
        logic [VLEN-1:0] ca;
        logic            cex, fv, rdy, fl, c;
        cw  = {rand_half(), rand_half()};
        ca  = 64'h0001_0000;
        cex = 1'b0;
        for (int i = 0; i < 800; i++) begin
            fv  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 49) == 0);
            tick(fv, cw, ca, cex, rdy, fl, c);
            if (fl) begin
                ca    = VLEN'(32'h0001_0000 + ($urandom_range(0, 1023) << 2));
                ca[1] = ($urandom_range(0, 1) == 1);
            end else if (c) begin
                ca = {ca[VLEN-1:2] + 1'b1, 2'b00};
            end
            if (fl || c) begin
                cw  = {rand_half(), rand_half()};
                cex = ($urandom_range(0, 29) == 0);
            end
        end
        drain(10);
    endtask

    initial begin
        test_reset();
        test_rvc_pair();
        test_straddle();
        test_hw_jump();
        test_ex_unaligned();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
